// File: rtl/branch_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Sequences the fetch redirect for taken MIPS branches and jumps. The EX
// branch unit reports a resolved branch; this block latches the target, waits
// until the architectural delay slot has entered the pipe, then presents a
// valid/ready redirect to IF. Wrong-path IF slots are killed in the meantime.
//
// Parameters
//   N_ISSUE         fetch slots per cycle (1..4)
//
// Ports
//   clk             clock
//   rst             synchronous reset, active-high
//   flush           pipeline flush (exception/eret), aborts any pending redirect
//   stall           pipeline stall, freezes the FSM and latched state
//   br_valid        branch resolved in EX this cycle
//   br_taken        resolved direction
//   br_pc           PC of the branch
//   br_target       resolved target
//   br_ds_fetched   delay slot of br_pc already past IF
//   fetch_valid     per-slot IF valid
//   fetch_pc        per-slot IF PCs, slot i at [32*i +: 32]
//   kill_mask       IF slots to drop this cycle (combinational)
//   redirect_valid  redirect request to IF
//   redirect_pc     redirect address
//   redirect_ready  IF accepts the redirect
//   busy            FSM is not idle
// ----------------------------------------------------------------------------
module branch_redirect_ctrl #(
    parameter int N_ISSUE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  br_valid,
    input  logic                  br_taken,
    input  logic [31:0]           br_pc,
    input  logic [31:0]           br_target,
    input  logic                  br_ds_fetched,
    input  logic [N_ISSUE-1:0]    fetch_valid,
    input  logic [N_ISSUE*32-1:0] fetch_pc,
    output logic [N_ISSUE-1:0]    kill_mask,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    input  logic                  redirect_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DS  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [31:0] ds_pc_q, ds_pc_d;

    logic [31:0]        in_ds_pc;
    logic [N_ISSUE-1:0] hit_in;
    logic [N_ISSUE-1:0] hit_wait;
    logic [N_ISSUE-1:0] kill_d;

    // Per-slot match of a valid fetch slot against the delay-slot PC.
    function automatic logic [N_ISSUE-1:0] ds_hit_vec(
        input logic [31:0]           pc,
        input logic [N_ISSUE-1:0]    valid,
        input logic [N_ISSUE*32-1:0] pcs
    );
        logic [N_ISSUE-1:0] hit;
        hit = '0;
        for (int i = 0; i < N_ISSUE; i++) begin
            hit[i] = valid[i] && (pcs[32*i +: 32] == pc);
        end
        return hit;
    endfunction

    // Bit i set when some lower slot hit: these are the slots younger than
    // the delay slot (lowest hit index k), i.e. wrong-path fetches.
    function automatic logic [N_ISSUE-1:0] above_first_hit(
        input logic [N_ISSUE-1:0] hit
    );
        logic [N_ISSUE-1:0] mask;
        logic               seen;
        mask = '0;
        seen = 1'b0;
        for (int i = 0; i < N_ISSUE; i++) begin
            mask[i] = seen;
            seen    = seen | hit[i];
        end
        return mask;
    endfunction

    // Delay slot sits at br_pc + 4; wrap past 0xFFFF_FFFC is intended.
    assign in_ds_pc = br_pc + 32'd4;
    assign hit_in   = ds_hit_vec(in_ds_pc, fetch_valid, fetch_pc);
    assign hit_wait = ds_hit_vec(ds_pc_q, fetch_valid, fetch_pc);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        ds_pc_d  = ds_pc_q;
        kill_d   = '0;
        case (state_q)
            IDLE: begin
                if (br_valid && br_taken) begin
                    target_d = br_target;
                    ds_pc_d  = in_ds_pc;
                    if (br_ds_fetched) begin
                        // Delay slot already downstream: everything in IF is wrong path.
                        state_d = REDIRECT;
                        kill_d  = fetch_valid;
                    end else if (|hit_in) begin
                        state_d = REDIRECT;
                        kill_d  = above_first_hit(hit_in) & fetch_valid;
                    end else begin
                        state_d = WAIT_DS;
                    end
                end
            end
            WAIT_DS: begin
                // A branch arriving here is ignored; the pending target stands.
                if (|hit_wait) begin
                    state_d = REDIRECT;
                    kill_d  = above_first_hit(hit_wait) & fetch_valid;
                end
            end
            REDIRECT: begin
                kill_d = fetch_valid;
                if (redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall freezes everything, so a ready seen during stall is not consumed.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q  <= IDLE;
            target_q <= '0;
            ds_pc_q  <= '0;
        end else if (!stall) begin
            state_q  <= state_d;
            target_q <= target_d;
            ds_pc_q  <= ds_pc_d;
        end
    end

    assign kill_mask      = rst ? '0 : kill_d;
    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = target_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst, flush, stall;
    logic          br_valid, br_taken, br_ds_fetched;
    logic [31:0]   br_pc, br_target;
    logic [N-1:0]  fetch_valid;
    logic [N*32-1:0] fetch_pc;
    logic [N-1:0]  kill_mask;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          redirect_ready;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.N_ISSUE(N)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc),
        .br_target(br_target), .br_ds_fetched(br_ds_fetched),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .kill_mask(kill_mask), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
        .busy(busy)
    );

    // Advance one clock; inputs are driven 1ns after the edge, outputs
    // are sampled 2ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_fetch(input logic [N-1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
        fetch_valid = v;
        fetch_pc    = {pc1, pc0};
    endtask

    task automatic set_br(input logic v, input logic t, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic dsf);
        br_valid = v; br_taken = t; br_pc = pc; br_target = tgt; br_ds_fetched = dsf;
    endtask

    task automatic idle_inputs();
        set_br(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_fetch(2'b00, 32'h0, 32'h0);
        flush = 1'b0; stall = 1'b0; redirect_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;
        settle();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b exp 0", redirect_valid); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", redirect_pc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (kill_mask !== 2'b00) begin errors++; $display("FAIL reset_kill got %b exp 00", kill_mask); end
        // Not-taken branch while idle does nothing.
        tick();
        set_br(1'b1, 1'b0, 32'h100, 32'h200, 1'b1);
        set_fetch(2'b11, 32'h300, 32'h304);
        settle();
        checks++; if (kill_mask !== 2'b00) begin errors++; $display("FAIL nt_kill got %b exp 00", kill_mask); end
        tick();
        idle_inputs();
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nt_busy got %b exp 0", busy); end
    endtask

    task automatic test_ds_fetched();
        set_br(1'b1, 1'b1, 32'h100, 32'h200, 1'b1);
        set_fetch(2'b01, 32'h300, 32'h0);
        redirect_ready = 1'b1;
        settle();
        checks++; if (kill_mask !== 2'b01) begin errors++; $display("FAIL t1_kill got %b exp 01", kill_mask); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL t1_rv0 got %b exp 0", redirect_valid); end
        tick();
        set_br(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL t1_rv got %b exp 1", redirect_valid); end
        checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL t1_pc got %h exp 200", redirect_pc); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b exp 1", busy); end
        checks++; if (kill_mask !== 2'b01) begin errors++; $display("FAIL t1_kill_r got %b exp 01", kill_mask); end
        tick();
        idle_inputs();
        settle();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL t1_rv_after got %b exp 0", redirect_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after got %b exp 0", busy); end
    endtask

    task automatic test_wait_ds();
        set_br(1'b1, 1'b1, 32'h100, 32'h400, 1'b0);
        settle();
        checks++; if (kill_mask !== 2'b00) begin errors++; $display("FAIL t2_kill0 got %b exp 00", kill_mask); end
        tick();
        // Branch while busy must not overwrite the pending target.
        set_br(1'b1, 1'b1, 32'h500, 32'h999, 1'b1);
        set_fetch(2'b11, 32'h600, 32'h604);
        settle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t2_busy got %b exp 1", busy); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL t2_rv_wait got %b exp 0", redirect_valid); end
        checks++; if (kill_mask !== 2'b00) begin errors++; $display("FAIL t2_kill_wait got %b exp 00", kill_mask); end
        tick();
        set_br(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_fetch(2'b11, 32'h104, 32'h108);
        settle();
        checks++; if (kill_mask !== 2'b10) begin errors++; $display("FAIL t2_kill_hit got %b exp 10", kill_mask); end
        tick();
        set_fetch(2'b00, 32'h0, 32'h0);
        redirect_ready = 1'b1;
        settle();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL t2_rv got %b exp 1", redirect_valid); end
        checks++; if (redirect_pc !== 32'h400) begin errors++; $display("FAIL t2_pc got %h exp 400", redirect_pc); end
        tick();
        idle_inputs();
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_done got %b exp 0", busy); end
    endtask

    task automatic test_idle_hit();
        // Slot 1 hits, slot 0 valid but older: nothing above slot 1 to kill.
        set_br(1'b1, 1'b1, 32'h1000, 32'h2000, 1'b0);
        set_fetch(2'b11, 32'h0FFC, 32'h1004);
        settle();
        checks++; if (kill_mask !== 2'b00) begin errors++; $display("FAIL ih_kill_s1 got %b exp 00", kill_mask); end
        // Duplicate hits: lowest index wins, slot 1 killed.
        set_fetch(2'b11, 32'h1004, 32'h1004);
        settle();
        checks++; if (kill_mask !== 2'b10) begin errors++; $display("FAIL ih_kill_dup got %b exp 10", kill_mask); end
        // Invalid slot 0 carrying the PC does not count as a hit.
        set_fetch(2'b10, 32'h1004, 32'h1008);
        settle();
        checks++; if (kill_mask !== 2'b00) begin errors++; $display("FAIL ih_kill_inv got %b exp 00", kill_mask); end
        set_fetch(2'b11, 32'h1004, 32'h1008);
        settle();
        checks++; if (kill_mask !== 2'b10) begin errors++; $display("FAIL ih_kill got %b exp 10", kill_mask); end
        tick();
        set_br(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        // Redirect held with ready low for three cycles.
        set_fetch(2'b11, 32'h2000, 32'h2004);
        settle();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL t3_rv1 got %b exp 1", redirect_valid); end
        checks++; if (kill_mask !== 2'b11) begin errors++; $display("FAIL t3_kill1 got %b exp 11", kill_mask); end
        tick();
        set_fetch(2'b01, 32'h2000, 32'h2004);
        settle();
        checks++; if (redirect_pc !== 32'h2000) begin errors++; $display("FAIL t3_pc2 got %h exp 2000", redirect_pc); end
        checks++; if (kill_mask !== 2'b01) begin errors++; $display("FAIL t3_kill2 got %b exp 01", kill_mask); end
        tick();
        set_fetch(2'b00, 32'h2000, 32'h2004);
        settle();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL t3_rv3 got %b exp 1", redirect_valid); end
        checks++; if (kill_mask !== 2'b00) begin errors++; $display("FAIL t3_kill3 got %b exp 00", kill_mask); end
        tick();
        redirect_ready = 1'b1;
        settle();
        checks++; if (redirect_pc !== 32'h2000) begin errors++; $display("FAIL t3_pc4 got %h exp 2000", redirect_pc); end
        tick();
        idle_inputs();
        settle();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL t3_done got %b exp 0", redirect_valid); end
    endtask

    task automatic test_flush();
        set_br(1'b1, 1'b1, 32'h700, 32'h800, 1'b0);
        tick();
        set_br(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_fetch(2'b01, 32'h704, 32'h0);
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_busy got %b exp 0", busy); end
        checks++; if (kill_mask !== 2'b00) begin errors++; $display("FAIL t4_kill got %b exp 00", kill_mask); end
        tick();
        settle();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL t4_rv got %b exp 0", redirect_valid); end
        // Flush in REDIRECT beats a simultaneous ready.
        idle_inputs();
        set_br(1'b1, 1'b1, 32'h900, 32'hA00, 1'b1);
        tick();
        set_br(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        flush = 1'b1; redirect_ready = 1'b1;
        settle();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL t4_rv_pre got %b exp 1", redirect_valid); end
        tick();
        idle_inputs();
        settle();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL t4_rv_fl got %b exp 0", redirect_valid); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL t4_pc_fl got %h exp 0", redirect_pc); end
    endtask

    task automatic test_stall();
        // Stall in IDLE blocks latching a taken branch.
        stall = 1'b1;
        set_br(1'b1, 1'b1, 32'hB00, 32'hC00, 1'b1);
        tick();
        set_br(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        stall = 1'b0;
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle_stall got %b exp 0", busy); end
        set_br(1'b1, 1'b1, 32'hB00, 32'hC00, 1'b1);
        tick();
        set_br(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        stall = 1'b1; redirect_ready = 1'b1;
        set_fetch(2'b11, 32'hD00, 32'hD04);
        settle();
        checks++; if (kill_mask !== 2'b11) begin errors++; $display("FAIL t5_kill got %b exp 11", kill_mask); end
        tick();
        settle();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL t5_rv_hold got %b exp 1", redirect_valid); end
        checks++; if (redirect_pc !== 32'hC00) begin errors++; $display("FAIL t5_pc_hold got %h exp c00", redirect_pc); end
        stall = 1'b0;
        tick();
        idle_inputs();
        settle();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL t5_acc got %b exp 0", redirect_valid); end
    endtask

    task automatic test_wrap();
        set_br(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h80, 1'b0);
        set_fetch(2'b01, 32'hFFFF_FFFC, 32'h0);
        settle();
        checks++; if (kill_mask !== 2'b00) begin errors++; $display("FAIL t6_kill0 got %b exp 00", kill_mask); end
        tick();
        set_br(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_fetch(2'b11, 32'h0, 32'h4);
        settle();
        checks++; if (kill_mask !== 2'b10) begin errors++; $display("FAIL t6_kill got %b exp 10", kill_mask); end
        tick();
        set_fetch(2'b00, 32'h0, 32'h0);
        redirect_ready = 1'b1;
        settle();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL t6_rv got %b exp 1", redirect_valid); end
        checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL t6_pc got %h exp 80", redirect_pc); end
        tick();
        idle_inputs();
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_done got %b exp 0", busy); end
    endtask

    initial begin
        #1;
        test_reset();
        test_ds_fetched();
        test_wait_ds();
        test_idle_hit();
        test_flush();
        test_stall();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
